// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory.
// Port 0 is the CPU path, port 1 the loader/DMA. A requester may hold
// the grant for a bounded burst through its lock input. Each access
// runs through IDLE -> ACCESS -> (WAIT for reads) -> DONE.
module mem_port_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 8
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          lock0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          grant,
  output logic          MemRead,
  output logic          MemWrite,
  output logic [AW-1:0] ADDR,
  output logic [DW-1:0] dataIn,
  input  logic [DW-1:0] MemOut
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [7:0] LOCK_MAX  = 8'(MAX_LOCK);
  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  state_t        state, state_nx;
  logic          last_grant;
  logic          lock_prev;
  logic [7:0]    lock_cnt;
  logic [1:0]    wait_cnt;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          win;

  // Winner: a lone requester wins; on a tie the previous owner keeps the
  // port while its lock window is open, otherwise the other port wins.
  always_comb begin
    win = 1'b0;
    if (req0 && !req1)
      win = 1'b0;
    else if (req1 && !req0)
      win = 1'b1;
    else if (lock_prev && (lock_cnt < LOCK_MAX))
      win = last_grant;
    else
      win = ~last_grant;
  end

  // State register.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state and memory/ack outputs; strobes are decoded from state so
  // an asynchronous reset drops them in the same cycle.
  always_comb begin
    state_nx = state;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ADDR     = '0;
    dataIn   = '0;
    ack0     = 1'b0;
    ack1     = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1)
          state_nx = ACCESS;
      end
      ACCESS: begin
        ADDR = lat_addr;
        if (lat_we) begin
          MemWrite = 1'b1;
          dataIn   = lat_wdata;
          state_nx = DONE;
        end else begin
          MemRead  = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == 2'd0)
          state_nx = DONE;
      end
      DONE: begin
        ack0     = ~grant;
        ack1     = grant;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latch the winner's request, count read latency, capture
  // read data and update round-robin / lock bookkeeping on completion.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      lock_prev  <= 1'b0;
      lock_cnt   <= '0;
      wait_cnt   <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant     <= win;
            lat_we    <= win ? we1    : we0;
            lat_addr  <= win ? addr1  : addr0;
            lat_wdata <= win ? wdata1 : wdata0;
          end
        end
        ACCESS: wait_cnt <= WAIT_INIT;
        WAIT: begin
          if (wait_cnt == 2'd0)
            rdata <= MemOut;
          else
            wait_cnt <= wait_cnt - 2'd1;
        end
        DONE: begin
          last_grant <= grant;
          lock_prev  <= grant ? lock1 : lock0;
          if (grant == last_grant)
            lock_cnt <= (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 8'd1;
          else
            lock_cnt <= 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single-port memory between two requesters: port 0 is the CPU fetch/load/store path, port 1 is the program loader/DMA.
- Sits between the requesters and the memory block, driving its MemRead, MemWrite, ADDR and write-data inputs.
- Uses round-robin arbitration, with an optional bounded lock for bursts.
- Every memory access is sequenced through a fixed multicycle handshake.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- RD_LAT, 1, memory read latency: cycles from the MemRead cycle to MemOut valid. Legal range 1..4.
- MAX_LOCK, 8, maximum consecutive grants to one locked requester. Legal range 1..255.

Ports:
- CLK  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req0  in  1  port-0 request; held high until ack0.
- we0  in  1  port-0 write enable (1 = write, 0 = read).
- addr0  in  AW  port-0 address.
- wdata0  in  DW  port-0 write data.
- lock0  in  1  port-0 requests grant retention for its next access.
- req1, we1, addr1, wdata1, lock1  in  1/1/AW/DW/1  port-1 equivalents.
- ack0  out  1  one-cycle pulse: port-0 transaction complete.
- ack1  out  1  one-cycle pulse: port-1 transaction complete.
- rdata  out  DW  read data, valid while ack0 or ack1 is high for a read.
- grant  out  1  id of the port owning the current transaction; meaningful outside IDLE.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- ADDR  out  AW  memory address.
- dataIn  out  DW  memory write data.
- MemOut  in  DW  memory read data.

Behaviour:
- Reset (async, reset=0): state=IDLE, grant=0, last_grant=1, lock_cnt=0. ack0, ack1, MemRead and MemWrite all 0. rdata, ADDR and dataIn are 0.
- Reset mid-transaction aborts it immediately: strobes drop, no ack is issued, and no partial state survives.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE, all strobes 0.
  - Otherwise pick a winner. On the clock edge, latch the winner's we/addr/wdata into internal registers, set grant=winner, go to ACCESS.
- Winner selection:
  - Only one req high: that port wins.
  - Both high, lock window open: if the previous owner (last_grant) had lock high when its last transaction ended and lock_cnt < MAX_LOCK, the previous owner wins.
  - Both high otherwise: the port != last_grant wins.
- ACCESS (exactly 1 cycle):
  - ADDR = latched address.
  - Write: MemWrite=1, dataIn = latched wdata, next state DONE.
  - Read: MemRead=1, next state WAIT.
- WAIT (read only, RD_LAT cycles, counted by an internal counter):
  - MemOut is captured into rdata on the edge ending the last WAIT cycle.
  - Next state DONE.
- DONE (exactly 1 cycle):
  - ack[grant]=1 and rdata held valid.
  - Update last_grant=grant.
  - lock_cnt: increment (saturating at MAX_LOCK) if the same port won consecutively, otherwise reset to 1.
  - Sample lock[grant] into lock_prev. Next state IDLE.
  - req is ignored in DONE.
- Latency:
  - Write: ack 2 cycles after the IDLE cycle that granted it.
  - Read: ack 2+RD_LAT cycles after the grant.
  - Back-to-back throughput: one write per 3 cycles; one read per 3+RD_LAT cycles.
- Requester rule: req must be deasserted on the edge at which ack is sampled high, unless a new transaction is intended. Requester inputs may change freely after the IDLE grant edge, because the arbiter uses only its latched copies.
- Only one of MemRead/MemWrite is ever high, and only in ACCESS. Never both.
- ack0 and ack1 are never high together.
- The non-granted port is never acked. Its req stays pending until it wins.
- Starvation bound: a continuously requesting port waits at most MAX_LOCK transactions of the other port.
- rdata keeps its last captured value after DONE. It is undefined for write acks; drive the previous value.

Test Plan:
- Reset then single read: req0=1, we0=0, addr0=0x0005, memory[5]=0xBEEF, RD_LAT=1 -> MemRead high exactly 1 cycle with ADDR=0x0005; ack0 pulses 3 cycles after the grant with rdata=0xBEEF; ack1 never high.
- Single write: req1=1, we1=1, addr1=0x0010, wdata1=0x1234 -> MemWrite high 1 cycle with ADDR=0x0010, dataIn=0x1234; ack1 pulses 2 cycles after the grant; a later read of 0x0010 returns 0x1234.
- Contention round-robin: req0 and req1 held high, lock0=lock1=0, four transactions -> grant sequence 0,1,0,1 (the first tie goes to port 0 after reset).
- Lock bound: MAX_LOCK=3, lock0=1, both requesting continuously -> grant sequence 0,0,0,1,0,0,0,1; no more than 3 consecutive port-0 acks.
- Reset mid-read: assert reset=0 during WAIT -> MemRead=0 and ack0=ack1=0 immediately (same cycle, asynchronous); after release with req0 still high, a fresh transaction completes normally.
- Input change after grant: change addr0 from 0x0005 to 0x0009 one cycle after the grant -> memory access still uses ADDR=0x0005.
